// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small byte FIFO feeding a frame serialiser.
// Bytes are sent LSB first at 16 baud enables per bit, with a configurable stop length.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_16_x_baud,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 buffer_write,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 buffer_data_present,
  output logic                 buffer_half_full,
  output logic                 buffer_full,
  output logic                 overflow
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned HALF   = 1 << (FIFO_AW - 1);
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned STOP_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full_now;
  logic                 wr_ok;
  logic                 pop;

  state_t               state;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     bit_idx;
  logic [STOP_W-1:0]    stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 last_tick;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign full_now  = (count == CNT_W'(DEPTH));
  assign wr_ok     = buffer_write && !full_now;
  assign pop       = en_16_x_baud && (state == IDLE) && (count != '0);
  assign last_tick = en_16_x_baud && (tick == TICK_W'(15));

  // FIFO storage; entries need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy count and the registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      overflow            <= 1'b0;
      buffer_data_present <= 1'b0;
      buffer_half_full    <= 1'b0;
      buffer_full         <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow            <= buffer_write && full_now;
      buffer_data_present <= (count != '0);
      buffer_half_full    <= (count >= CNT_W'(HALF));
      buffer_full         <= full_now;
    end
  end

  // Frame serialiser; the line and busy are registered so serial_out never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      stop_idx   <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (pop) begin
            shift      <= mem[rd_ptr];
            state      <= START;
            tick       <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (last_tick) begin
            state      <= DATA;
            tick       <= '0;
            bit_idx    <= '0;
            serial_out <= shift[0];
          end else if (en_16_x_baud) begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (last_tick) begin
            tick <= '0;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state      <= STOP;
              stop_idx   <= '0;
              serial_out <= 1'b1;
            end else begin
              shift      <= shift >> 1;
              bit_idx    <= bit_idx + IDX_W'(1);
              serial_out <= shift[1];
            end
          end else if (en_16_x_baud) begin
            tick <= tick + TICK_W'(1);
          end
        end
        STOP: begin
          if (last_tick) begin
            tick <= '0;
            if (stop_idx == STOP_W'(STOP_BITS - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= stop_idx + STOP_W'(1);
            end
          end else if (en_16_x_baud) begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of queued bytes checked by a line monitor.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       en_16_x_baud;
  logic [7:0] data_in;
  logic       buffer_write;
  logic       serial_out, busy, buffer_data_present, buffer_half_full, buffer_full, overflow;

  logic [6:0] data_in2;
  logic       buffer_write2;
  logic       serial_out2, busy2, present2, half2, full2, overflow2;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb_q[$];
  bit         mon_abort = 1'b0;
  int         en_period = 0;
  logic       en_pulse = 1'b0;

  uart_tx_fifo dut (
    .clk                 (clk),
    .reset               (reset),
    .en_16_x_baud        (en_16_x_baud),
    .data_in             (data_in),
    .buffer_write        (buffer_write),
    .serial_out          (serial_out),
    .busy                (busy),
    .buffer_data_present (buffer_data_present),
    .buffer_half_full    (buffer_half_full),
    .buffer_full         (buffer_full),
    .overflow            (overflow)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_AW(4), .STOP_BITS(2)) dut72 (
    .clk                 (clk),
    .reset               (reset),
    .en_16_x_baud        (en_16_x_baud),
    .data_in             (data_in2),
    .buffer_write        (buffer_write2),
    .serial_out          (serial_out2),
    .busy                (busy2),
    .buffer_data_present (present2),
    .buffer_half_full    (half2),
    .buffer_full         (full2),
    .overflow            (overflow2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // en_period: 0 = no enables, 1 = tied high, N>1 = one pulse every N clk
  assign en_16_x_baud = (en_period == 1) || ((en_period > 1) && en_pulse);

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (en_period > 1) begin
        cnt      = (cnt >= en_period - 1) ? 0 : cnt + 1;
        en_pulse = (cnt == 0);
      end else begin
        cnt      = 0;
        en_pulse = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in      = b;
    buffer_write = 1'b1;
    sb_q.push_back(b);
    @(negedge clk);
    buffer_write = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  // Line monitor: decodes each 8N1 frame, checks exact slot timing and busy against the scoreboard.
  initial begin
    int         p, good, busy_n, idle;
    bit         pending, aborted;
    logic [7:0] exp_b, got_b;
    logic       exp_bit;
    pending = 1'b0;
    idle    = 0;
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        pending = 1'b0;
      end else if (serial_out === 1'b0) begin
        if (pending) check("frame_gap", 32'(idle), 32'd1);
        pending = 1'b0;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          exp_b = 8'h00;
        end else begin
          exp_b = sb_q.pop_front();
        end
        p       = (en_period == 1) ? 16 : 16 * en_period;
        got_b   = 8'h00;
        busy_n  = 0;
        aborted = 1'b0;
        for (int k = 0; k < 10; k++) begin
          exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_b[k-1];
          good    = 0;
          for (int j = 0; j < p; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (mon_abort) begin
              aborted = 1'b1;
              break;
            end
            if (serial_out === exp_bit) good++;
            if (busy === 1'b1) busy_n++;
            if (k >= 1 && k <= 8 && j == p / 2) got_b[k-1] = serial_out;
          end
          if (aborted) break;
          check("bit_slot", 32'(good), 32'(p));
        end
        if (!aborted) begin
          check("frame_byte", 32'(got_b), 32'(exp_b));
          check("busy_len", 32'(busy_n), 32'(10 * p));
          pending = (sb_q.size() != 0);
          idle    = 0;
        end else begin
          pending = 1'b0;
        end
      end else if (pending) begin
        idle++;
      end
    end
  end

  initial begin
    int lows, good, bz, n;
    reset         = 1'b1;
    buffer_write  = 1'b0;
    buffer_write2 = 1'b0;
    data_in       = 8'h00;
    data_in2      = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_state", 32'({serial_out, busy, buffer_data_present, buffer_half_full, buffer_full, overflow}), 32'h20);
    check("rst_state72", 32'({serial_out2, busy2, present2}), 32'h4);
    reset = 1'b0;

    // single byte 0x55, enables tied high
    en_period = 1;
    @(negedge clk);
    write_byte(8'h55);
    check("pre_pop_line", 32'(serial_out), 32'd1);
    @(negedge clk);
    check("start_low", 32'(serial_out), 32'd0);
    check("present_at_pop", 32'(buffer_data_present), 32'd1);
    @(negedge clk);
    check("present_drop", 32'(buffer_data_present), 32'd0);
    wait_drain(400);
    check("busy_after_55", 32'(busy), 32'd0);

    // real baud: one enable every 326 clk
    en_period = 326;
    @(negedge clk);
    write_byte(8'hA3);
    wait_drain(60000);
    check("busy_after_a3", 32'(busy), 32'd0);

    // burst of 17 writes with no enables
    en_period = 0;
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      data_in      = 8'(k);
      buffer_write = 1'b1;
      if (k < 16) sb_q.push_back(8'(k));
      @(negedge clk);
      check("burst_half", 32'(buffer_half_full), 32'(k >= 8));
      check("burst_full", 32'(buffer_full), 32'(k >= 16));
      check("burst_ovf", 32'(overflow), 32'(k == 16));
    end
    buffer_write = 1'b0;
    @(negedge clk);
    check("ovf_single", 32'(overflow), 32'd0);
    check("full_held", 32'(buffer_full), 32'd1);
    en_period = 1;
    wait_drain(4000);
    @(negedge clk);
    check("burst_flags_clear", 32'({buffer_data_present, buffer_half_full, buffer_full}), 32'd0);

    // write in the same clk as the IDLE pop
    en_period = 0;
    write_byte(8'h3C);
    en_period    = 1;
    data_in      = 8'hC3;
    buffer_write = 1'b1;
    sb_q.push_back(8'hC3);
    @(negedge clk);
    buffer_write = 1'b0;
    check("wp_start", 32'(serial_out), 32'd0);
    @(negedge clk);
    check("wp_count1_a", 32'(buffer_data_present), 32'd1);
    @(negedge clk);
    check("wp_count1_b", 32'({buffer_data_present, buffer_half_full}), 32'h2);
    wait_drain(800);

    // reset during DATA bit 3 of 0x0F with more bytes queued
    write_byte(8'h0F);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    repeat (67) @(negedge clk);
    check("mid_bit3", 32'(serial_out), 32'd1);
    mon_abort = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check("rst_mid", 32'({serial_out, busy, buffer_data_present, buffer_half_full, buffer_full, overflow}), 32'h20);
    reset = 1'b0;
    sb_q.delete();
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("no_frames_after_rst", 32'(lows), 32'd0);
    mon_abort = 1'b0;
    write_byte(8'h81);
    wait_drain(400);
    check("busy_after_81", 32'(busy), 32'd0);

    // 7 data bits, 2 stop bits
    data_in2      = 7'h7F;
    buffer_write2 = 1'b1;
    @(negedge clk);
    buffer_write2 = 1'b0;
    n = 0;
    while (serial_out2 !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("f72_start_seen", 32'(n < 10), 32'd1);
    good = 0;
    bz   = 0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      if (serial_out2 === ((i < 16) ? 1'b0 : 1'b1)) good++;
      if (busy2 === 1'b1) bz++;
    end
    check("f72_line", 32'(good), 32'd160);
    check("f72_busy", 32'(bz), 32'd160);
    @(negedge clk);
    check("f72_end", 32'({serial_out2, busy2}), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
